set_sched: RTL and testbench

Round-robin job scheduler in front of a single SET candidate-counting engine. Accepts circle-set jobs (central, radius, mode) from NREQ independent requesters, and issues them one at a time over the engine's en/busy handshake. It captures the engine's 8-bit candidate and returns it to the owning requester with its index. Sits between the host-side requesters and the shared engine; no job is ever dropped or reordered per requester.

---
 rtl/set_sched.sv | 180 ++++++++++++++++++
 tb/tb_set_sched.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/set_sched.sv
// set_sched: round-robin scheduler that feeds one shared SET candidate-counting engine.
// Define SET_SCHED_TIMEOUT_EN to add the ISSUE/WAIT watchdog (limit set by TIMEOUT).
module set_sched #(
    parameter int NREQ    = 4,
    parameter int IDW     = 3,
    parameter int TIMEOUT = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [24*NREQ-1:0]   req_central,
    input  logic [12*NREQ-1:0]   req_radius,
    input  logic [2*NREQ-1:0]    req_mode,
    output logic [NREQ-1:0]      req_ready,
    output logic                 eng_en,
    output logic [23:0]          eng_central,
    output logic [11:0]          eng_radius,
    output logic [1:0]           eng_mode,
    input  logic                 eng_busy,
    input  logic                 eng_valid,
    input  logic [7:0]           eng_candidate,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [7:0]           rsp_candidate,
    output logic                 rsp_err,
    output logic                 sched_busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    if (NREQ < 2 || NREQ > 8 || IDW < $clog2(NREQ) || TIMEOUT < 1) begin : g_cfg_check
        $error("set_sched: illegal NREQ/IDW/TIMEOUT combination");
    end

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  job_id_q, job_id_d;
    logic [23:0]     central_q, central_d;
    logic [11:0]     radius_q, radius_d;
    logic [1:0]      mode_q, mode_d;
    logic [7:0]      cand_q, cand_d;
    logic            win_found;
    int              win_idx;

`ifdef SET_SCHED_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    logic [WDW-1:0]  wd_q, wd_d;
    logic            err_q, err_d;
    logic            wd_hit;

    assign wd_hit = (wd_q == WDW'(TIMEOUT));
`endif

    // Search ptr, ptr+1, .. with wrap; the first pending requester wins.
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!win_found && req_valid[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        for (int k = 0; k < NREQ; k++) begin
            req_ready[k] = (state_q == IDLE) && win_found && (win_idx == k);
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        job_id_d  = job_id_q;
        central_d = central_q;
        radius_d  = radius_q;
        mode_d    = mode_q;
        cand_d    = cand_q;
`ifdef SET_SCHED_TIMEOUT_EN
        wd_d      = wd_q;
        err_d     = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    central_d = req_central[24*win_idx +: 24];
                    radius_d  = req_radius[12*win_idx +: 12];
                    mode_d    = req_mode[2*win_idx +: 2];
                    job_id_d  = IDW'(win_idx);
                    state_d   = ISSUE;
`ifdef SET_SCHED_TIMEOUT_EN
                    wd_d      = '0;
                    err_d     = 1'b0;
`endif
                end
            end
            ISSUE: begin
                if (!eng_busy) begin
                    state_d = WAIT;
                end
`ifdef SET_SCHED_TIMEOUT_EN
                wd_d = wd_q + 1'b1;
                if (wd_hit) begin
                    state_d = RESP;
                    cand_d  = 8'd0;
                    err_d   = 1'b1;
                end
`endif
            end
            WAIT: begin
`ifdef SET_SCHED_TIMEOUT_EN
                wd_d = wd_q + 1'b1;
                // A result arriving on the limit cycle still counts as a normal result.
                if (wd_hit && !eng_valid) begin
                    state_d = RESP;
                    cand_d  = 8'd0;
                    err_d   = 1'b1;
                end
`endif
                if (eng_valid) begin
                    cand_d  = eng_candidate;
                    state_d = RESP;
                end
            end
            RESP: begin
                ptr_d   = (job_id_q == IDW'(NREQ - 1)) ? '0 : job_id_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            job_id_q  <= '0;
            central_q <= '0;
            radius_q  <= '0;
            mode_q    <= '0;
            cand_q    <= '0;
`ifdef SET_SCHED_TIMEOUT_EN
            wd_q      <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            job_id_q  <= job_id_d;
            central_q <= central_d;
            radius_q  <= radius_d;
            mode_q    <= mode_d;
            cand_q    <= cand_d;
`ifdef SET_SCHED_TIMEOUT_EN
            wd_q      <= wd_d;
            err_q     <= err_d;
`endif
        end
    end

    assign eng_en        = (state_q == ISSUE);
    assign eng_central   = central_q;
    assign eng_radius    = radius_q;
    assign eng_mode      = mode_q;
    assign rsp_valid     = (state_q == RESP);
    assign rsp_id        = job_id_q;
    assign rsp_candidate = cand_q;
    assign sched_busy    = (state_q != IDLE);
`ifdef SET_SCHED_TIMEOUT_EN
    assign rsp_err       = err_q;
`else
    assign rsp_err       = 1'b0;
`endif

endmodule

// File: tb/tb_set_sched.sv
// Scoreboard bench for set_sched: requester jobs push expected results, responses pop them.
// A behavioural engine model answers accepted jobs after a programmable latency.
module tb_set_sched;
    localparam int NREQ = 4;
    localparam int IDW  = 3;
`ifdef SET_SCHED_TIMEOUT_EN
    localparam int TMO = 50;
`else
    localparam int TMO = 1023;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [24*NREQ-1:0]  req_central;
    logic [12*NREQ-1:0]  req_radius;
    logic [2*NREQ-1:0]   req_mode;
    logic [NREQ-1:0]     req_ready;
    logic                eng_en;
    logic [23:0]         eng_central;
    logic [11:0]         eng_radius;
    logic [1:0]          eng_mode;
    logic                eng_busy;
    logic                eng_valid;
    logic [7:0]          eng_candidate;
    logic                rsp_valid;
    logic [IDW-1:0]      rsp_id;
    logic [7:0]          rsp_candidate;
    logic                rsp_err;
    logic                sched_busy;

    set_sched #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_central(req_central), .req_radius(req_radius),
        .req_mode(req_mode), .req_ready(req_ready),
        .eng_en(eng_en), .eng_central(eng_central), .eng_radius(eng_radius),
        .eng_mode(eng_mode), .eng_busy(eng_busy), .eng_valid(eng_valid),
        .eng_candidate(eng_candidate),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_candidate(rsp_candidate),
        .rsp_err(rsp_err), .sched_busy(sched_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [7:0]     cand;
        logic           err;
    } exp_t;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [23:0]    c;
        logic [11:0]    r;
        logic [1:0]     m;
        logic           tmo;
    } job_t;

    int n_chk = 0;
    int n_pass = 0;
    exp_t sb[$];
    job_t pend[$];
    int   rsp_log[$];
    int   rsp_total = 0, accepts = 0, stall_left = 0, stall_seen = 0;
    int   eng_lat = 195, cnt = 0, cyc = 0, issue_cyc = 0;
    bit   pending = 0, have_snap = 0, mute = 0, stray_req = 0;
    bit   grant_prev = 0, prev_eng_valid = 0, en_prev = 0, acc = 0;
    logic [37:0]     snap;
    logic [7:0]      pend_cand, last_cand;
    logic [IDW-1:0]  last_id;
    logic [NREQ-1:0] xfer;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Behavioural engine: candidate depends on every job bit; the reference job yields 29.
    function automatic logic [7:0] eng_fn(input logic [23:0] c, input logic [11:0] r,
                                          input logic [1:0] m);
        if (c == 24'h444400 && r == 12'h300 && m == 2'd0) return 8'd29;
        return (c[7:0] + 8'd3 * c[15:8] + 8'd7 * c[23:16]) ^ r[7:0] ^ {r[11:8], 2'b10, m};
    endfunction

    task automatic add_job(input int id, input logic [23:0] c, input logic [11:0] r,
                           input logic [1:0] m, input bit tmo);
        job_t j;
        j.id = IDW'(id); j.c = c; j.r = r; j.m = m; j.tmo = tmo;
        pend.push_back(j);
    endtask

    task automatic add_rand(input int id, input bit tmo);
        add_job(id, 24'($urandom), 12'($urandom), 2'($urandom), tmo);
    endtask

    // One clock: sample/check at negedge, drive engine and requesters #1 after posedge.
    task automatic step(input bit chk_rst = 1'b0);
        int   found;
        exp_t e;
        job_t jb;
        @(negedge clk);
        cyc++;
        if (chk_rst) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_eng_en", eng_en, 0);
            chk("rst_eng_central", eng_central, 0);
            chk("rst_eng_radius", eng_radius, 0);
            chk("rst_eng_mode", eng_mode, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_id", rsp_id, 0);
            chk("rst_rsp_candidate", rsp_candidate, 0);
            chk("rst_rsp_err", rsp_err, 0);
            chk("rst_sched_busy", sched_busy, 0);
        end
        if (rsp_valid) begin
            rsp_total++;
            rsp_log.push_back(int'(rsp_id));
            last_cand = rsp_candidate;
            last_id   = rsp_id;
            found = -1;
            for (int j = 0; j < sb.size(); j++)
                if (found < 0 && sb[j].id == rsp_id) found = j;
            chk("rsp_expected", found >= 0, 1);
            if (found >= 0) begin
                e = sb[found];
                sb.delete(found);
                chk("rsp_candidate", rsp_candidate, e.cand);
                chk("rsp_err", rsp_err, e.err);
                if (e.err) chk("timeout_latency", cyc - issue_cyc, 51);
                else       chk("rsp_after_eng_valid", prev_eng_valid, 1);
            end
        end
        if (req_ready != 0) begin
            chk("ready_onehot", $countones(req_ready), 1);
            chk("ready_subset_valid", req_ready & ~req_valid, 0);
            chk("ready_only_idle", sched_busy, 0);
        end
        if (grant_prev) chk("en_after_grant", eng_en, 1);
        xfer = rst ? '0 : (req_valid & req_ready);
        grant_prev = !rst && (xfer != 0);
        if (eng_en && !en_prev) issue_cyc = cyc;
        if (eng_en) begin
            if (!have_snap) begin
                snap = {eng_central, eng_radius, eng_mode};
                have_snap = 1;
            end else begin
                chk("issue_fields_stable", {eng_central, eng_radius, eng_mode}, snap);
            end
            if (eng_busy) begin
                stall_seen++;
                if (stall_left > 0) stall_left--;
            end
        end
        acc = !rst && eng_en && !eng_busy;
        if (acc) begin
            pend_cand = eng_fn(eng_central, eng_radius, eng_mode);
            have_snap = 0;
        end
        if (rst) begin
            sb.delete();
            pending = 0;
            have_snap = 0;
        end
        prev_eng_valid = eng_valid;
        en_prev = eng_en;

        @(posedge clk);
        #1;
        eng_valid = 1'b0;
        if (acc) begin
            accepts++;
            pending = 1;
            cnt = eng_lat;
        end else if (pending) begin
            cnt--;
            if (cnt <= 0) begin
                pending = 0;
                if (!mute) begin
                    eng_valid = 1'b1;
                    eng_candidate = pend_cand;
                end
            end
        end
        if (stray_req) begin
            eng_valid = 1'b1;
            eng_candidate = 8'h5A;
            stray_req = 0;
        end
        eng_busy = (stall_left > 0);
        for (int i = 0; i < NREQ; i++) if (xfer[i]) req_valid[i] = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i]) begin
                found = -1;
                for (int j = 0; j < pend.size(); j++)
                    if (found < 0 && pend[j].id == IDW'(i)) found = j;
                if (found >= 0) begin
                    jb = pend[found];
                    pend.delete(found);
                    req_central[24*i +: 24] = jb.c;
                    req_radius[12*i +: 12]  = jb.r;
                    req_mode[2*i +: 2]      = jb.m;
                    req_valid[i]            = 1'b1;
                    e.id   = jb.id;
                    e.err  = jb.tmo;
                    e.cand = jb.tmo ? 8'd0 : eng_fn(jb.c, jb.r, jb.m);
                    sb.push_back(e);
                end
            end
        end
    endtask

    task automatic run_rsp(input int n, input int budget);
        int start;
        start = rsp_total;
        for (int k = 0; k < budget && rsp_total < start + n; k++) step();
        chk("rsp_count", rsp_total - start, n);
    endtask

    initial begin
        int a0, n0;
        int exp_rr[5] = '{0, 1, 2, 3, 0};
        rst = 1'b1;
        req_valid = '0; req_central = '0; req_radius = '0; req_mode = '0;
        eng_busy = 1'b0; eng_valid = 1'b0; eng_candidate = '0;
        @(posedge clk);
        #1;
        step(1'b1);
        rst = 1'b0;

        add_job(0, 24'h444400, 12'h300, 2'd0, 1'b0);
        a0 = accepts;
        run_rsp(1, 400);
        chk("single_cand", last_cand, 29);
        chk("single_id", last_id, 0);
        chk("single_accepts", accepts - a0, 1);

        repeat (3) step();
        n0 = rsp_total;
        stray_req = 1;
        repeat (5) step();
        chk("stray_ignored", rsp_total, n0);

        stall_left = 20;
        stall_seen = 0;
        a0 = accepts;
        add_rand(2, 1'b0);
        run_rsp(1, 600);
        chk("stall_cycles", stall_seen, 20);
        chk("stall_accepts", accepts - a0, 1);

        add_rand(1, 1'b0);
        a0 = accepts;
        for (int k = 0; k < 50 && accepts == a0; k++) step();
        repeat (5) step();
        chk("in_wait_busy", sched_busy, 1);
        chk("in_wait_en_low", eng_en, 0);
        n0 = rsp_total;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step(1'b1);
        repeat (250) step();
        chk("abandoned_no_rsp", rsp_total, n0);

        eng_lat = 30;
        rsp_log.delete();
        add_rand(0, 1'b0);
        add_rand(1, 1'b0);
        add_rand(2, 1'b0);
        add_rand(3, 1'b0);
        add_rand(0, 1'b0);
        run_rsp(5, 1500);
        for (int k = 0; k < 5; k++) chk("rr_order", (k < rsp_log.size()) ? rsp_log[k] : -1, exp_rr[k]);

`ifdef SET_SCHED_TIMEOUT_EN
        mute = 1;
        eng_lat = 5;
        add_rand(3, 1'b1);
        run_rsp(1, 200);
        mute = 0;
        repeat (10) step();
`endif

        repeat (5) step();
        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
